// File: rtl/axi_ntt_resp_m_pkg.sv
// Shared AXI encodings and FSM state types for the NoC transaction tester pair.
// Imported by both the responder and the master tester.
package axi_ntt_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Only full-width incrementing bursts are served; anything else gets SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst,
                                    input logic [2:0] size,
                                    input logic [2:0] full_size);
    return (burst == BURST_INCR) && (size == full_size);
  endfunction

endpackage

// File: rtl/axi_ntt_resp_m_if.sv
// AXI4 channel bundle between the NoC transaction tester master and its responder.
// Sideband fields (cache/lock/prot/qos/region/user) are carried but not interpreted.
interface axi_ntt_resp_m_if #(
  parameter int DATA_W = 64
);
  localparam int WSTRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [63:0]       awaddr;
  logic [1:0]        awburst;
  logic [1:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [3:0]        awcache;
  logic              awlock;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic [3:0]        awregion;
  logic [17:0]       awuser;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [WSTRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bid;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [63:0]       araddr;
  logic [1:0]        arburst;
  logic [1:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [3:0]        arcache;
  logic              arlock;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic [17:0]       aruser;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rid;
  logic              rlast;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awburst, awid, awlen, awsize,
           awcache, awlock, awprot, awqos, awregion, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arburst, arid, arlen, arsize,
           arcache, arlock, arprot, arqos, arregion, aruser,
    input  arready,
    input  rvalid, rdata, rid, rlast, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awburst, awid, awlen, awsize,
           awcache, awlock, awprot, awqos, awregion, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arburst, arid, arlen, arsize,
           arcache, arlock, arprot, arqos, arregion, aruser,
    output arready,
    output rvalid, rdata, rid, rlast, rresp,
    input  rready
  );

endinterface

// File: rtl/axi_ntt_resp_m_ram.sv
// Word memory behind the responder: one byte-enabled write port, one async read port.
// Contents are deliberately not reset so data survives a tester reset.
module axi_ntt_ram_m #(
  parameter int DATA_W = 64,
  parameter int MEM_AW = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [MEM_AW-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Async read: a write landing on the same edge is not yet visible to the reader.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_ntt_resp_m.sv
// AXI4 slave responder terminating NoC tester traffic in a local word memory.
// Independent write and read FSMs, protocol checking, sticky error and burst counters.
module axi_ntt_resp_m
  import axi_ntt_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MEM_AW = 10
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_ntt_resp_m_if.slave  bus,
  output logic [15:0]      wr_bursts,
  output logic [15:0]      rd_bursts,
  output logic             err
);

  localparam int         WSTRB_W   = DATA_W / 8;
  localparam int         LSB       = $clog2(WSTRB_W);
  localparam logic [2:0] FULL_SIZE = 3'(LSB);

  logic rst_q;

  wr_state_t         w_state;
  logic [MEM_AW-1:0] w_idx;
  logic [7:0]        w_len;
  logic              w_ok;
  logic [8:0]        w_beat;

  rd_state_t         r_state;
  logic [MEM_AW-1:0] r_idx;
  logic [7:0]        r_len;
  logic              r_ok;
  logic [8:0]        r_beat;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              w_bad, ar_ok;
  logic [MEM_AW-1:0] aw_idx, ar_idx;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_bits;

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign b_hs   = bus.bvalid && bus.bready;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign r_hs   = bus.rvalid && bus.rready;

  assign aw_idx = bus.awaddr[LSB +: MEM_AW];
  assign ar_idx = bus.araddr[LSB +: MEM_AW];
  assign ar_ok  = burst_ok(bus.arburst, bus.arsize, FULL_SIZE);
  assign w_bad  = !w_ok || (w_beat != {1'b0, w_len});

  // Beats past the announced length are accepted but never reach memory.
  assign mem_we    = (w_state == W_DATA) && w_hs && w_ok && (w_beat <= {1'b0, w_len});
  assign mem_raddr = (r_state == R_IDLE) ? ar_idx : r_idx;

  assign unused_bits = ^{bus.awcache, bus.awlock, bus.awprot, bus.awqos, bus.awregion,
                         bus.awuser, bus.arcache, bus.arlock, bus.arprot, bus.arqos,
                         bus.arregion, bus.aruser,
                         bus.awaddr[63:LSB+MEM_AW], bus.awaddr[LSB-1:0],
                         bus.araddr[63:LSB+MEM_AW], bus.araddr[LSB-1:0]};

  axi_ntt_ram_m #(
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk   (aclk),
    .we    (mem_we),
    .waddr (w_idx),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Holds the address-ready outputs low for one extra cycle after reset release.
  always_ff @(posedge aclk) begin
    rst_q <= !aresetn;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bid     <= '0;
      bus.bresp   <= RESP_OKAY;
      w_idx       <= '0;
      w_len       <= '0;
      w_ok        <= 1'b0;
      w_beat      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            bus.bid     <= bus.awid;
            w_idx       <= aw_idx;
            w_len       <= bus.awlen;
            w_ok        <= burst_ok(bus.awburst, bus.awsize, FULL_SIZE);
            w_beat      <= '0;
            w_state     <= W_DATA;
          end else begin
            bus.awready <= !rst_q;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx  <= w_idx + MEM_AW'(1);
            w_beat <= w_beat + 9'd1;
            if (bus.wlast) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bresp  <= w_bad ? RESP_SLVERR : RESP_OKAY;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data is registered from the async RAM port so each beat holds until rready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rid     <= '0;
      bus.rlast   <= 1'b0;
      bus.rresp   <= RESP_OKAY;
      r_idx       <= '0;
      r_len       <= '0;
      r_ok        <= 1'b0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            bus.rid     <= bus.arid;
            bus.rdata   <= ar_ok ? mem_rdata : '0;
            bus.rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            bus.rlast   <= (bus.arlen == 8'd0);
            r_idx       <= ar_idx + MEM_AW'(1);
            r_len       <= bus.arlen;
            r_ok        <= ar_ok;
            r_beat      <= '0;
            r_state     <= R_DATA;
          end else begin
            bus.arready <= !rst_q;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (bus.rlast) begin
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              bus.rdata <= r_ok ? mem_rdata : '0;
              bus.rlast <= ((r_beat + 9'd1) == {1'b0, r_len});
              r_idx     <= r_idx + MEM_AW'(1);
              r_beat    <= r_beat + 9'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // err is raised on the edge an SLVERR response first goes out on B or R.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_bursts <= '0;
      rd_bursts <= '0;
      err       <= 1'b0;
    end else begin
      if (b_hs) wr_bursts <= wr_bursts + 16'd1;
      if (r_hs && bus.rlast) rd_bursts <= rd_bursts + 16'd1;
      if (((w_state == W_DATA) && w_hs && bus.wlast && w_bad) || (ar_hs && !ar_ok)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ntt_resp_m.sv
// Self-checking bench for axi_ntt_resp_m: a transaction-level memory/response model
// checked every cycle, directed scenarios pinned by literals, then random traffic.
`timescale 1ns/1ps
module tb_axi_ntt_resp_m;
  import axi_ntt_pkg::*;

  localparam int DATA_W = 64;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1024;
  localparam int MAXW   = 2000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] wr_bursts, rd_bursts;
  logic        err;

  axi_ntt_resp_m_if #(.DATA_W(DATA_W)) bus ();

  axi_ntt_resp_m #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .wr_bursts (wr_bursts),
    .rd_bursts (rd_bursts),
    .err       (err)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem_model [DEPTH];
  bit          chk_en = 1'b0;
  bit          exp_awready, exp_wready, exp_bvalid, exp_arready, exp_rvalid;
  logic [1:0]  exp_bid, exp_bresp, exp_rid;
  logic [63:0] exp_rdata_q [$];
  logic [1:0]  exp_rresp_q [$];
  int          model_wr, model_rd;
  bit          model_err;

  logic [63:0] wbuf [$];
  logic [7:0]  sbuf [$];
  logic [63:0] cap_q [$];
  logic [1:0]  last_bresp, last_bid;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no handshake within %0d cycles at %0t", name, MAXW, $time);
  endtask

  // Every-cycle comparison of the DUT against the transaction model.
  always @(negedge aclk) begin
    if (chk_en) begin
      checkOutput("awready", 64'(bus.awready), 64'(exp_awready));
      checkOutput("wready", 64'(bus.wready), 64'(exp_wready));
      checkOutput("bvalid", 64'(bus.bvalid), 64'(exp_bvalid));
      checkOutput("arready", 64'(bus.arready), 64'(exp_arready));
      checkOutput("rvalid", 64'(bus.rvalid), 64'(exp_rvalid));
      if (exp_bvalid) begin
        checkOutput("bid", 64'(bus.bid), 64'(exp_bid));
        checkOutput("bresp", 64'(bus.bresp), 64'(exp_bresp));
      end
      if (exp_rvalid && exp_rdata_q.size() > 0) begin
        checkOutput("rdata", bus.rdata, exp_rdata_q[0]);
        checkOutput("rid", 64'(bus.rid), 64'(exp_rid));
        checkOutput("rresp", 64'(bus.rresp), 64'(exp_rresp_q[0]));
        checkOutput("rlast", 64'(bus.rlast), 64'(exp_rdata_q.size() == 1));
      end
      checkOutput("wr_bursts", 64'(wr_bursts), 64'(model_wr[15:0]));
      checkOutput("rd_bursts", 64'(rd_bursts), 64'(model_rd[15:0]));
      checkOutput("err", 64'(err), 64'(model_err));
    end
  end

  task automatic applyReset(input int cycles);
    chk_en      = 1'b0;
    aresetn     = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    @(posedge aclk); #1;
    exp_awready = 1'b0; exp_wready = 1'b0; exp_bvalid = 1'b0;
    exp_arready = 1'b0; exp_rvalid = 1'b0;
    exp_rdata_q.delete();
    exp_rresp_q.delete();
    model_wr  = 0;
    model_rd  = 0;
    model_err = 1'b0;
    chk_en    = 1'b1;
    repeat (cycles) begin
      @(posedge aclk); #1;
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    exp_awready = 1'b1;
    exp_arready = 1'b1;
  endtask

  task automatic randomSideband();
    bus.awcache = 4'($urandom); bus.awlock = 1'($urandom); bus.awprot = 3'($urandom);
    bus.awqos = 4'($urandom); bus.awregion = 4'($urandom); bus.awuser = 18'($urandom);
    bus.arcache = 4'($urandom); bus.arlock = 1'($urandom); bus.arprot = 3'($urandom);
    bus.arqos = 4'($urandom); bus.arregion = 4'($urandom); bus.aruser = 18'($urandom);
  endtask

  // Write burst from wbuf/sbuf; wl is the beat carrying wlast.
  task automatic applyStimulusWrite(input logic [63:0] addr, input int len, input logic [1:0] burst,
                                    input logic [2:0] size, input int wl, input logic [1:0] id,
                                    input bit stall);
    int idx, n;
    bit ok, bad, hs;
    idx = int'(addr[12:3]);
    ok  = (burst == BURST_INCR) && (size == 3'd3);
    bad = !ok || (wl != len);
    randomSideband();
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awburst = burst;
    bus.awsize = size; bus.awid = id; bus.awvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge aclk);
      if (bus.awready) break;
      @(posedge aclk); #1;
      if (++n > MAXW) begin timeoutFail("aw_wait"); bus.awvalid = 1'b0; return; end
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    exp_awready = 1'b0;
    exp_wready  = 1'b1;
    for (int b = 0; b <= wl; b++) begin
      bus.wdata = wbuf[b];
      bus.wstrb = sbuf[b];
      bus.wlast = (b == wl);
      n = 0;
      while (1) begin
        bus.wvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge aclk);
        hs = bus.wvalid && bus.wready;
        @(posedge aclk); #1;
        if (hs) break;
        if (++n > MAXW) begin timeoutFail("w_wait"); bus.wvalid = 1'b0; return; end
      end
      if (ok && b <= len) begin
        for (int k = 0; k < 8; k++) begin
          if (sbuf[b][k]) mem_model[(idx + b) % DEPTH][k*8 +: 8] = wbuf[b][k*8 +: 8];
        end
      end
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    exp_wready = 1'b0;
    exp_bvalid = 1'b1;
    exp_bid    = id;
    exp_bresp  = bad ? RESP_SLVERR : RESP_OKAY;
    if (bad) model_err = 1'b1;
    n = 0;
    while (1) begin
      bus.bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      hs = bus.bvalid && bus.bready;
      if (hs) begin last_bresp = bus.bresp; last_bid = bus.bid; end
      @(posedge aclk); #1;
      if (hs) break;
      if (++n > MAXW) begin timeoutFail("b_wait"); bus.bready = 1'b0; return; end
    end
    bus.bready  = 1'b0;
    exp_bvalid  = 1'b0;
    exp_awready = 1'b1;
    model_wr++;
  endtask

  // rmode: 0 rready high, 1 toggling from high, 2 random. abort >= 0 stops after that many beats.
  task automatic applyStimulusRead(input logic [63:0] addr, input int len, input logic [1:0] burst,
                                   input logic [2:0] size, input logic [1:0] id,
                                   input int rmode, input int abort);
    int idx, n, t, got;
    bit ok, hs;
    idx = int'(addr[12:3]);
    ok  = (burst == BURST_INCR) && (size == 3'd3);
    randomSideband();
    bus.araddr = addr; bus.arlen = 8'(len); bus.arburst = burst;
    bus.arsize = size; bus.arid = id; bus.arvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge aclk);
      if (bus.arready) break;
      @(posedge aclk); #1;
      if (++n > MAXW) begin timeoutFail("ar_wait"); bus.arvalid = 1'b0; return; end
    end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    exp_arready = 1'b0;
    exp_rvalid  = 1'b1;
    exp_rid     = id;
    if (!ok) model_err = 1'b1;
    for (int b = 0; b <= len; b++) begin
      exp_rdata_q.push_back(ok ? mem_model[(idx + b) % DEPTH] : 64'd0);
      exp_rresp_q.push_back(ok ? RESP_OKAY : RESP_SLVERR);
    end
    cap_q.delete();
    got = 0; t = 0; n = 0;
    while (exp_rdata_q.size() > 0) begin
      if (abort >= 0 && got == abort) begin bus.rready = 1'b0; return; end
      case (rmode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (t % 2 == 0);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      t++;
      @(negedge aclk);
      hs = bus.rvalid && bus.rready;
      if (hs) cap_q.push_back(bus.rdata);
      @(posedge aclk); #1;
      if (hs) begin
        void'(exp_rdata_q.pop_front());
        void'(exp_rresp_q.pop_front());
        got++;
        n = 0;
        if (exp_rdata_q.size() == 0) begin
          exp_rvalid  = 1'b0;
          exp_arready = 1'b1;
          model_rd++;
        end
      end else if (++n > MAXW) begin
        timeoutFail("r_wait");
        bus.rready = 1'b0;
        return;
      end
    end
    bus.rready = 1'b0;
  endtask

  task automatic fillBuf(input int beats, input logic [63:0] base, input logic [7:0] strb, input bit rnd);
    wbuf.delete();
    sbuf.delete();
    for (int b = 0; b < beats; b++) begin
      wbuf.push_back(rnd ? {$urandom, $urandom} : base * 64'(b + 1));
      sbuf.push_back(rnd ? 8'($urandom) : strb);
    end
  endtask

  task automatic checkCaptured(input string name, input logic [63:0] v0, input logic [63:0] v1,
                               input logic [63:0] v2, input logic [63:0] v3, input int cnt);
    logic [63:0] want [4];
    want[0] = v0; want[1] = v1; want[2] = v2; want[3] = v3;
    checkOutput({name, "_count"}, 64'(cap_q.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < cap_q.size(); i++) checkOutput(name, cap_q[i], want[i]);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, wl;
    logic [1:0] burst;
    logic [2:0] size;
    logic [63:0] addr;

    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.rready = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awsize = '0; bus.awid = '0;
    bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arsize = '0; bus.arid = '0;
    randomSideband();

    applyReset(3);
    for (int p = 0; p < 4; p++) begin
      fillBuf(256, 64'd0, 8'hFF, 1'b1);
      for (int b = 0; b < 256; b++) sbuf[b] = 8'hFF;
      applyStimulusWrite(64'(p * 256 * 8), 255, BURST_INCR, 3'd3, 255, 2'd0, 1'b0);
    end
    applyReset(2);
    checkOutput("reset_wr_bursts", 64'(wr_bursts), 64'd0);
    checkOutput("reset_awready", 64'(bus.awready), 64'd1);

    $display("[TB] basic write burst");
    fillBuf(4, 64'h11, 8'hFF, 1'b0);
    applyStimulusWrite(64'h40, 3, BURST_INCR, 3'd3, 3, 2'd2, 1'b0);
    checkOutput("t1_bresp", 64'(last_bresp), 64'd0);
    checkOutput("t1_bid", 64'(last_bid), 64'd2);
    checkOutput("t1_wr_bursts", 64'(wr_bursts), 64'd1);

    bus.wvalid = 1'b1; bus.wlast = 1'b1;
    repeat (3) begin @(posedge aclk); #1; end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;

    $display("[TB] read burst with rready toggling");
    applyStimulusRead(64'h40, 3, BURST_INCR, 3'd3, 2'd1, 1, -1);
    checkCaptured("t2_rdata", 64'h11, 64'h22, 64'h33, 64'h44, 4);
    checkOutput("t2_rd_bursts", 64'(rd_bursts), 64'd1);

    $display("[TB] partial strobe");
    fillBuf(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    applyStimulusWrite(64'h80, 0, BURST_INCR, 3'd3, 0, 2'd3, 1'b0);
    fillBuf(1, 64'h1234_5678_9ABC_DEF0, 8'h0F, 1'b0);
    applyStimulusWrite(64'h80, 0, BURST_INCR, 3'd3, 0, 2'd3, 1'b0);
    applyStimulusRead(64'h80, 0, BURST_INCR, 3'd3, 2'd0, 0, -1);
    checkCaptured("t3_rdata", 64'hFFFF_FFFF_9ABC_DEF0, 64'd0, 64'd0, 64'd0, 1);

    $display("[TB] protocol errors");
    fillBuf(4, 64'hDEAD, 8'hFF, 1'b0);
    applyStimulusWrite(64'h40, 3, BURST_FIXED, 3'd3, 3, 2'd1, 1'b0);
    checkOutput("t4_fixed_bresp", 64'(last_bresp), 64'd2);
    checkOutput("t4_err", 64'(err), 64'd1);
    applyStimulusRead(64'h40, 3, BURST_INCR, 3'd3, 2'd2, 0, -1);
    checkCaptured("t4_unchanged", 64'h11, 64'h22, 64'h33, 64'h44, 4);
    fillBuf(2, 64'hBEEF, 8'hFF, 1'b0);
    applyStimulusWrite(64'h60, 3, BURST_INCR, 3'd3, 1, 2'd0, 1'b0);
    checkOutput("t4_early_wlast_bresp", 64'(last_bresp), 64'd2);
    applyStimulusRead(64'h40, 2, BURST_INCR, 3'd2, 2'd3, 0, -1);
    checkCaptured("t4_badsize_rdata", 64'd0, 64'd0, 64'd0, 64'd0, 3);
    checkOutput("t4_err_sticky", 64'(err), 64'd1);

    $display("[TB] index wrap");
    fillBuf(2, 64'hA1, 8'hFF, 1'b0);
    applyStimulusWrite(64'hABCD_0000_0000_1FF8, 1, BURST_INCR, 3'd3, 1, 2'd1, 1'b0);
    applyStimulusRead(64'h1FF8, 1, BURST_INCR, 3'd3, 2'd1, 0, -1);
    checkCaptured("t5_wrap", 64'hA1, 64'h142, 64'd0, 64'd0, 2);
    applyStimulusRead(64'h0, 0, BURST_INCR, 3'd3, 2'd1, 0, -1);
    checkCaptured("t5_idx0", 64'h142, 64'd0, 64'd0, 64'd0, 1);

    $display("[TB] reset in the middle of a read");
    applyStimulusRead(64'h40, 3, BURST_INCR, 3'd3, 2'd2, 0, 1);
    applyReset(2);
    checkOutput("t6_rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("t6_rdata", bus.rdata, 64'd0);
    checkOutput("t6_rd_bursts", 64'(rd_bursts), 64'd0);
    checkOutput("t6_err", 64'(err), 64'd0);
    applyStimulusRead(64'h40, 3, BURST_INCR, 3'd3, 2'd0, 2, -1);
    checkCaptured("t6_mem_kept", 64'h11, 64'h22, 64'h33, 64'h44, 4);

    $display("[TB] random traffic");
    for (int k = 0; k < 40; k++) begin
      addr  = {$urandom, $urandom};
      len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 7));
      burst = ($urandom_range(0, 9) != 0) ? BURST_INCR
            : (($urandom_range(0, 1) == 0) ? BURST_FIXED : BURST_WRAP);
      size  = ($urandom_range(0, 9) != 0) ? 3'd3 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        wl = len;
        if ($urandom_range(0, 7) == 0) wl = len + 1;
        else if ($urandom_range(0, 7) == 0 && len > 0) wl = len - 1;
        fillBuf(wl + 1, 64'd0, 8'hFF, 1'b1);
        applyStimulusWrite(addr, len, burst, size, wl, 2'($urandom), 1'b1);
      end else begin
        applyStimulusRead(addr, len, burst, size, 2'($urandom), 2, -1);
      end
    end

    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
